// File: rtl/ser_pkg.sv
// Shared types and line levels for the serial transmit scheduler.
package ser_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int   FRAME_BITS = 8;
    localparam logic START_LVL  = 1'b0;
    localparam logic IDLE_LVL   = 1'b1;

endpackage

// File: rtl/ser_tx_sched_rr_arb.sv
// Combinational round-robin pick: first set request above ptr, else the
// lowest set request overall, which is the wrap-around continuation.
module rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any_req
);

    localparam int IW = $clog2(N);

    logic          hi_found;
    logic          lo_found;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
            end
            if (req[i] && (i > int'(ptr)) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
        end
        any_req = |req;
        idx     = hi_found ? hi_idx : lo_idx;
        onehot  = any_req ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/ser_tx_sched.sv
// Round-robin scheduler that serializes one granted byte per frame:
// start bit, 8 data bits MSB-first, then GAP_BITS high stop bits.
module ser_tx_sched
    import ser_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int GAP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     out,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] cur_id
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = ($clog2(GAP_BITS + 1) > 3) ? $clog2(GAP_BITS + 1) : 3;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [FRAME_BITS-1:0]   shreg, shreg_nxt;
    logic [IW-1:0]           ptr, ptr_nxt;
    logic [IW-1:0]           cur_id_nxt;
    logic [N_REQ-1:0]        gnt_nxt;
    logic                    out_nxt;
    logic                    busy_nxt;
    logic                    arb;

    logic [N_REQ-1:0]        win_onehot;
    logic [IW-1:0]           win_idx;
    logic                    any_req;
    logic [FRAME_BITS-1:0]   win_byte;
    logic [FRAME_BITS-1:0]   bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign bytes[g] = data[FRAME_BITS*g +: FRAME_BITS];
    end

    rr_arb #(.N(N_REQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .onehot  (win_onehot),
        .idx     (win_idx),
        .any_req (any_req)
    );

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IW'(i)) win_byte = bytes[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            ptr    <= IW'(N_REQ - 1);
            gnt    <= '0;
            out    <= IDLE_LVL;
            busy   <= 1'b0;
            cur_id <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shreg  <= shreg_nxt;
            ptr    <= ptr_nxt;
            gnt    <= gnt_nxt;
            out    <= out_nxt;
            busy   <= busy_nxt;
            cur_id <= cur_id_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shreg_nxt  = shreg;
        ptr_nxt    = ptr;
        gnt_nxt    = '0;
        out_nxt    = out;
        busy_nxt   = busy;
        cur_id_nxt = cur_id;
        arb        = 1'b0;

        case (state)
            IDLE: begin
                out_nxt  = IDLE_LVL;
                busy_nxt = 1'b0;
                arb      = 1'b1;
            end
            START: begin
                out_nxt   = shreg[FRAME_BITS-1];
                state_nxt = DATA;
                cnt_nxt   = '0;
            end
            DATA: begin
                shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
                out_nxt   = shreg[FRAME_BITS-2];
                cnt_nxt   = cnt + CW'(1);
                if (cnt == CW'(FRAME_BITS - 1)) begin
                    out_nxt   = IDLE_LVL;
                    state_nxt = STOP;
                    cnt_nxt   = '0;
                end
            end
            STOP: begin
                out_nxt = IDLE_LVL;
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(GAP_BITS - 1)) begin
                    arb       = 1'b1;
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A win at the last stop edge chains straight into the next start bit.
        if (arb && any_req) begin
            shreg_nxt  = win_byte;
            gnt_nxt    = win_onehot;
            cur_id_nxt = win_idx;
            ptr_nxt    = win_idx;
            out_nxt    = START_LVL;
            busy_nxt   = 1'b1;
            state_nxt  = START;
            cnt_nxt    = '0;
        end
    end

endmodule

// File: doc/ser_tx_sched.md
Name: ser_tx_sched

Overview:
- Round-robin scheduler and serializer that shares one serial output line among N_REQ byte requesters.
- Each granted byte is sent as one frame: start bit 0, 8 data bits MSB-first, then GAP_BITS stop/idle bits at 1.
- The line changes on posedge clk, so a downstream deserializer that samples on negedge clk sees stable bits.
- Sits between the parallel producers and the serial link.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- GAP_BITS, 1, number of high stop bits after each frame; minimum 1 (the receiver needs one high sample to re-arm).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request; held high until the grant is seen.
- data  in  8*N_REQ  flattened bytes; requester i uses data[8*i+7:8*i]; stable while req[i]=1.
- gnt  out  N_REQ  one-hot, one-cycle accept pulse; the byte is captured on the same edge that raises gnt.
- out  out  1  serial line; idles high.
- busy  out  1  high while a frame (start, data or stop) is on the line.
- cur_id  out  $clog2(N_REQ)  index of the requester whose frame is on the line.

Behaviour:
- Reset (async, rst_n=0):
  - out=1, gnt=0, busy=0, cur_id=0, state=IDLE.
  - Bit counter=0, shift register=0, round-robin pointer=N_REQ-1, so requester 0 has first priority.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - out=1, busy=0.
  - If any req bit is high at a posedge, on that edge:
    - Pick the winner: first set bit searching upward from pointer+1, with wrap-around.
    - shreg<=data[winner], gnt<=onehot(winner), cur_id<=winner, pointer<=winner.
    - out<=0, busy<=1, state<=START.
- START (1 cycle): gnt returns to 0 on the next edge; out<=shreg[7]; state<=DATA; counter<=0.
- DATA (8 cycles):
  - Each edge: shift shreg left one bit, out<=next MSB, counter+1.
  - When counter==7: out<=1, state<=STOP, counter<=0.
- STOP (GAP_BITS cycles):
  - out=1; counter increments.
  - On the final STOP edge, arbitration is performed exactly as in IDLE:
    - If any req is high: go straight to START with the new byte, so back-to-back frames are 9+GAP_BITS cycles apart.
    - Otherwise: state<=IDLE, busy<=0.
- Latency: req high at edge E → gnt high in cycle E..E+1 → start bit on line in the same cycle → last data bit ends 9 cycles after E.
- Requester rules:
  - req may drop before being granted (request withdrawn, no frame).
  - If req is still high the cycle after gnt, it is treated as a new request for the current data value.
  - req and data are ignored while busy, except at the final-STOP arbitration edge.
- Fairness: with all req held high, grants rotate 0,1,2,...,N_REQ-1,0.
- Simultaneous events: only one grant per arbitration edge; losing requesters keep waiting, with no starvation.
- Reset mid-frame: line forced to 1 immediately and the frame is truncated. Downstream may latch a partial byte; this is accepted, and no resend is performed.
- Width rules:
  - The bit counter is 3 bits, sized max(3, $clog2(GAP_BITS+1)).
  - The pointer wraps modulo N_REQ, including non-power-of-2 values.

Decomposition:
- Package ser_pkg:
  - State enum (IDLE, START, DATA, STOP).
  - FRAME_BITS=8, START_LVL=1'b0, IDLE_LVL=1'b1.
- Sub-module rr_arb:
  - Combinational round-robin pick.
  - Inputs: req and pointer. Outputs: onehot and index, with an any_req flag.
  - Reused elsewhere.

Test Plan:
- Single frame: rst_n deasserted, req=4'b0001, data0=8'hA5.
  - gnt[0] pulses once.
  - out sequence from the grant edge: 0,1,0,1,0,0,1,0,1, then 1 (stop).
  - Negedge loopback deserializer reports 8'hA5; busy high for exactly 10 cycles.
- Contention: req=4'b1010 with data1=8'h3C, data3=8'hC3.
  - Requester 1 is served first, then 3, back-to-back.
  - Start bits are 10 cycles apart; received bytes are 3C then C3.
- Fairness: all four req held high for 8 frames → grant order 0,1,2,3,0,1,2,3.
- Withdrawal: req[2] pulsed high for 1 cycle while busy, then dropped → no gnt[2] and no extra frame.
- Reset mid-frame: assert rst_n=0 during DATA bit 4.
  - out=1, busy=0 and gnt=0 asynchronously.
  - After release with req=4'b0100, requester 2 is granted first (pointer reset to N_REQ-1).
- GAP_BITS=3 build: back-to-back frames have exactly 3 high cycles between the last data bit and the next start bit.
